// File: rtl/bf_io_buffer_if.sv
// Handshake bundle between the host stream side, the brainfuck core
// character strobes, and the buffered I/O bridge.
interface bf_io_buffer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  host_rx_valid;
   logic [DATA_WIDTH-1:0] host_rx_data;
   logic                  host_rx_ready;
   logic                  host_tx_valid;
   logic [DATA_WIDTH-1:0] host_tx_data;
   logic                  host_tx_ready;
   logic                  core_in_req;
   logic                  core_in_valid;
   logic [DATA_WIDTH-1:0] core_in_data;
   logic                  core_out_valid;
   logic [DATA_WIDTH-1:0] core_out_data;

   modport master (
      output host_rx_valid, host_rx_data,
      input  host_rx_ready,
      input  host_tx_valid, host_tx_data,
      output host_tx_ready,
      output core_in_req,
      input  core_in_valid, core_in_data,
      output core_out_valid, core_out_data
   );

   modport slave (
      input  host_rx_valid, host_rx_data,
      output host_rx_ready,
      output host_tx_valid, host_tx_data,
      input  host_tx_ready,
      input  core_in_req,
      output core_in_valid, core_in_data,
      input  core_out_valid, core_out_data
   );
endinterface

// File: rtl/bf_io_buffer.sv
// Buffered character bridge: host RX FIFO feeding the core's ',' requests,
// and a first-word fall-through TX FIFO draining the core's '.' strobes.
module bf_io_buffer #(
   parameter int DATA_WIDTH    = 8,
   parameter int RX_DEPTH_LOG2 = 4,
   parameter int TX_DEPTH_LOG2 = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   bf_io_buffer_if.slave          bus,
   output logic [RX_DEPTH_LOG2:0] rx_count,
   output logic [TX_DEPTH_LOG2:0] tx_count,
   output logic                   tx_overflow
);
   localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
   localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
   localparam logic [RX_DEPTH_LOG2:0] RX_FULL =
      (RX_DEPTH_LOG2 + 1)'(RX_DEPTH);
   localparam logic [TX_DEPTH_LOG2:0] TX_FULL =
      (TX_DEPTH_LOG2 + 1)'(TX_DEPTH);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_SERVED = 1'b1;

   logic [DATA_WIDTH-1:0]    rx_mem [RX_DEPTH];
   logic [RX_DEPTH_LOG2-1:0] rx_wptr;
   logic [RX_DEPTH_LOG2-1:0] rx_rptr;
   logic [0:0]               state;
   logic                     rx_full;
   logic                     rx_empty;
   logic                     rx_push;
   logic                     rx_pop;

   logic [DATA_WIDTH-1:0]    tx_mem [TX_DEPTH];
   logic [TX_DEPTH_LOG2-1:0] tx_wptr;
   logic [TX_DEPTH_LOG2-1:0] tx_rptr;
   logic                     tx_full;
   logic                     tx_empty;
   logic                     tx_push;
   logic                     tx_pop;

   assign rx_full  = (rx_count == RX_FULL);
   assign rx_empty = (rx_count == '0);
   assign rx_push  = bus.host_rx_valid && !rx_full;
   assign rx_pop   = (state == ST_IDLE) && bus.core_in_req && !rx_empty;

   assign bus.host_rx_ready = !rx_full;

   assign tx_full  = (tx_count == TX_FULL);
   assign tx_empty = (tx_count == '0);
   assign tx_pop   = !tx_empty && bus.host_tx_ready;
   // A full FIFO still takes a character when the head leaves this cycle
   assign tx_push  = bus.core_out_valid && (!tx_full || tx_pop);

   assign bus.host_tx_valid = !tx_empty;
   assign bus.host_tx_data  = tx_mem[tx_rptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RX_DEPTH; i++) rx_mem[i] <= '0;
         rx_wptr           <= '0;
         rx_rptr           <= '0;
         rx_count          <= '0;
         state             <= ST_IDLE;
         bus.core_in_valid <= 1'b0;
         bus.core_in_data  <= '0;
      end else begin
         if (rx_push) begin
            rx_mem[rx_wptr] <= bus.host_rx_data;
            rx_wptr         <= rx_wptr + 1'b1;
         end
         if (rx_pop) begin
            bus.core_in_data <= rx_mem[rx_rptr];
            rx_rptr          <= rx_rptr + 1'b1;
         end
         bus.core_in_valid <= rx_pop;
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase
         // One delivery per request assertion: re-arm only once req drops
         case (state)
            ST_IDLE:   if (rx_pop) state <= ST_SERVED;
            ST_SERVED: if (!bus.core_in_req) state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TX_DEPTH; i++) tx_mem[i] <= '0;
         tx_wptr     <= '0;
         tx_rptr     <= '0;
         tx_count    <= '0;
         tx_overflow <= 1'b0;
      end else begin
         if (tx_push) begin
            tx_mem[tx_wptr] <= bus.core_out_data;
            tx_wptr         <= tx_wptr + 1'b1;
         end
         if (tx_pop) tx_rptr <= tx_rptr + 1'b1;
         if (bus.core_out_valid && !tx_push) tx_overflow <= 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: tx_count <= tx_count;
         endcase
      end
   end
endmodule

// File: tb/tb_bf_io_buffer.sv
// Scoreboard bench: queue-based reference model predicts deliveries and
// TX characters; a monitor compares them against the bridge each cycle.
module tb_bf_io_buffer;
   localparam int DW  = 8;
   localparam int RXL = 2;
   localparam int TXL = 2;
   localparam int RXD = 1 << RXL;
   localparam int TXD = 1 << TXL;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [RXL:0]   rx_count;
   logic [TXL:0]   tx_count;
   logic           tx_overflow;

   bf_io_buffer_if #(.DATA_WIDTH(DW)) bus ();

   bf_io_buffer #(
      .DATA_WIDTH(DW), .RX_DEPTH_LOG2(RXL), .TX_DEPTH_LOG2(TXL)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .rx_count(rx_count), .tx_count(tx_count),
      .tx_overflow(tx_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      int            c;
   } exp_t;

   logic [DW-1:0] rxq[$];
   exp_t          exp_in[$];
   logic [DW-1:0] exp_tx[$];
   int            m_txn;
   bit            m_ovf;
   bit            m_served;
   int            cyc;
   int            n_checks;
   int            n_errors;

   function automatic void chk(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endfunction

   // Reference model: FIFOs as plain queues/counters, updated per edge
   always @(posedge clk) begin
      int   rx_pre;
      bit   tx_pop;
      exp_t e;
      cyc++;
      if (reset) begin
         rxq.delete();
         exp_in.delete();
         exp_tx.delete();
         m_txn    = 0;
         m_ovf    = 0;
         m_served = 0;
      end else begin
         rx_pre = rxq.size();
         tx_pop = (m_txn > 0) && bus.host_tx_ready;
         if (m_served) begin
            if (!bus.core_in_req) m_served = 0;
         end else if (bus.core_in_req && rx_pre > 0) begin
            e.d = rxq.pop_front();
            e.c = cyc;
            exp_in.push_back(e);
            m_served = 1;
         end
         if (bus.host_rx_valid && rx_pre < RXD)
            rxq.push_back(bus.host_rx_data);
         if (tx_pop) m_txn--;
         if (bus.core_out_valid) begin
            if (m_txn < TXD) begin
               m_txn++;
               exp_tx.push_back(bus.core_out_data);
            end else begin
               m_ovf = 1;
            end
         end
      end
   end

   // Monitor: sampled mid-low-phase, after inputs for the next edge settle
   always begin
      bit exp_v;
      @(negedge clk);
      #2;
      chk("rx_count", int'(rx_count), rxq.size());
      chk("tx_count", int'(tx_count), m_txn);
      chk("tx_overflow", int'(tx_overflow), int'(m_ovf));
      chk("host_rx_ready", int'(bus.host_rx_ready), int'(rxq.size() < RXD));
      chk("host_tx_valid", int'(bus.host_tx_valid), int'(m_txn > 0));
      exp_v = (exp_in.size() > 0) && (exp_in[0].c == cyc);
      chk("core_in_valid", int'(bus.core_in_valid), int'(exp_v));
      if (exp_v) begin
         chk("core_in_data", int'(bus.core_in_data), int'(exp_in[0].d));
         void'(exp_in.pop_front());
      end
      if (!reset && bus.host_tx_valid && bus.host_tx_ready) begin
         if (exp_tx.size() == 0) begin
            chk("host_tx_unexpected", 1, 0);
         end else begin
            chk("host_tx_data", int'(bus.host_tx_data), int'(exp_tx[0]));
            void'(exp_tx.pop_front());
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic idle_inputs();
      bus.host_rx_valid  = 1'b0;
      bus.host_rx_data   = '0;
      bus.host_tx_ready  = 1'b0;
      bus.core_in_req    = 1'b0;
      bus.core_out_valid = 1'b0;
      bus.core_out_data  = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic host_push(logic [DW-1:0] d);
      bus.host_rx_valid = 1'b1;
      bus.host_rx_data  = d;
      step();
      bus.host_rx_valid = 1'b0;
   endtask

   task automatic core_strobe(logic [DW-1:0] d);
      bus.core_out_valid = 1'b1;
      bus.core_out_data  = d;
      step();
      bus.core_out_valid = 1'b0;
   endtask

   initial begin
      idle_inputs();
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      do_reset();
      chk("reset_rx_ready", int'(bus.host_rx_ready), 1);
      chk("reset_tx_valid", int'(bus.host_tx_valid), 0);
      chk("reset_rx_count", int'(rx_count), 0);
      chk("reset_tx_count", int'(tx_count), 0);
      chk("reset_in_data", int'(bus.core_in_data), 0);

      // One character per request assertion
      host_push(8'h41);
      host_push(8'h42);
      bus.core_in_req = 1'b1;
      step(10);
      chk("held_req_rx_count", int'(rx_count), 1);
      chk("held_req_data", int'(bus.core_in_data), 8'h41);
      bus.core_in_req = 1'b0;
      step(2);
      bus.core_in_req = 1'b1;
      step(3);
      chk("second_req_rx_count", int'(rx_count), 0);
      chk("second_req_data", int'(bus.core_in_data), 8'h42);
      bus.core_in_req = 1'b0;
      step(2);

      // Request waiting on an empty FIFO
      bus.core_in_req = 1'b1;
      step(5);
      host_push(8'h2B);
      step(4);
      chk("late_push_data", int'(bus.core_in_data), 8'h2B);
      bus.core_in_req = 1'b0;
      step(2);

      // RX backpressure
      for (int i = 0; i < 6; i++) host_push(8'h60 + 8'(i));
      chk("rx_full_count", int'(rx_count), RXD);
      chk("rx_full_ready", int'(bus.host_rx_ready), 0);
      for (int i = 0; i < RXD; i++) begin
         bus.core_in_req = 1'b1;
         step(2);
         bus.core_in_req = 1'b0;
         step(2);
      end
      chk("rx_drained_data", int'(bus.core_in_data), 8'h63);

      // Full TX with simultaneous push and pop
      for (int i = 0; i < TXD; i++) core_strobe(8'h50 + 8'(i));
      bus.host_tx_ready  = 1'b1;
      bus.core_out_valid = 1'b1;
      bus.core_out_data  = 8'h54;
      step();
      bus.host_tx_ready  = 1'b0;
      bus.core_out_valid = 1'b0;
      step();
      chk("full_pushpop_count", int'(tx_count), TXD);
      chk("full_pushpop_ovf", int'(tx_overflow), 0);
      bus.host_tx_ready = 1'b1;
      step(6);
      bus.host_tx_ready = 1'b0;

      // TX overflow
      for (int i = 0; i < 5; i++) core_strobe(8'h30 + 8'(i));
      step();
      chk("ovf_count", int'(tx_count), TXD);
      chk("ovf_flag", int'(tx_overflow), 1);
      bus.host_tx_ready = 1'b1;
      step(6);
      bus.host_tx_ready = 1'b0;
      chk("ovf_sticky", int'(tx_overflow), 1);

      // Reset mid-operation
      host_push(8'h11);
      host_push(8'h12);
      core_strobe(8'h21);
      core_strobe(8'h22);
      bus.core_in_req = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midreset_rx_count", int'(rx_count), 0);
      chk("midreset_tx_count", int'(tx_count), 0);
      chk("midreset_ovf", int'(tx_overflow), 0);
      step(3);
      bus.core_in_req = 1'b0;
      step();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.host_rx_valid  = ($urandom_range(1) == 0);
         bus.host_rx_data   = DW'($urandom);
         bus.core_out_valid = ($urandom_range(2) == 0);
         bus.core_out_data  = DW'($urandom);
         bus.host_tx_ready  = ($urandom_range(1) == 0);
         if ($urandom_range(3) == 0) bus.core_in_req = !bus.core_in_req;
         reset = ($urandom_range(599) == 0);
         step();
      end
      idle_inputs();
      reset = 1'b0;
      bus.host_tx_ready = 1'b1;
      step(TXD + 4);
      chk("final_tx_drained", exp_tx.size(), 0);
      chk("final_tx_count", int'(tx_count), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
